// File: rtl/i2c_sensor_poller.sv
`default_nettype none
// ============================================================================
// Module : i2c_sensor_poller
// Brief  : I2C register sequencer (burst read, convert-then-read, periodic poll)
//          driving a byte-level I2C master command interface.
// Rev    : 1.0
// ============================================================================
module i2c_sensor_poller #(
    parameter logic [6:0] DEV_ADDR       = 7'h77,
    parameter int         MAX_BYTES      = 8,
    parameter int         CONV_CYCLES    = 225000,
    parameter int         POLL_CYCLES    = 5000000,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         LEN_W          = $clog2(MAX_BYTES + 1),
    parameter int         IDX_W          = $clog2(MAX_BYTES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             poll_en,
    input  logic             conv_en,
    input  logic [7:0]       conv_reg,
    input  logic [7:0]       conv_val,
    input  logic [7:0]       rd_reg,
    input  logic [LEN_W-1:0] rd_len,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic             tmo_err,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic [IDX_W-1:0] rd_idx,
    output logic [2:0]       m_cmd,
    output logic             m_valid,
    output logic [7:0]       m_wdata,
    input  logic             m_done,
    input  logic             m_ack,
    input  logic [7:0]       m_rdata
);

    localparam logic [2:0] c_cmd_start = 3'd1;
    localparam logic [2:0] c_cmd_write = 3'd2;
    localparam logic [2:0] c_cmd_rack  = 3'd3;
    localparam logic [2:0] c_cmd_rnack = 3'd4;
    localparam logic [2:0] c_cmd_stop  = 3'd5;

    localparam int c_cnt_max = (TIMEOUT_CYCLES > CONV_CYCLES)
        ? ((TIMEOUT_CYCLES > POLL_CYCLES) ? TIMEOUT_CYCLES : POLL_CYCLES)
        : ((CONV_CYCLES > POLL_CYCLES) ? CONV_CYCLES : POLL_CYCLES);
    localparam int CNT_W = $clog2(c_cnt_max + 1);

    localparam logic [CNT_W-1:0] c_conv_last = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_poll_last = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_tmo_last  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_C_START, ST_C_ADDR, ST_C_REG, ST_C_VAL, ST_C_STOP, ST_WAIT,
        ST_R_START, ST_R_ADDRW, ST_R_REG, ST_R_RSTART, ST_R_ADDRR, ST_R_READ, ST_STOP
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               nack_q, nack_d, tmo_q, tmo_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [2:0]         m_cmd_q, m_cmd_d;
    logic               m_valid_q, m_valid_d;
    logic [7:0]         m_wdata_q, m_wdata_d;
    logic [7:0]         creg_q, creg_d, cval_q, cval_d, rreg_q, rreg_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         w_cmd;
    logic [7:0]         w_wdata;
    logic               w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            tmo_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
            m_cmd_q    <= '0;
            m_valid_q  <= 1'b0;
            m_wdata_q  <= '0;
            creg_q     <= '0;
            cval_q     <= '0;
            rreg_q     <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            tmo_q      <= tmo_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_idx_q   <= rd_idx_d;
            m_cmd_q    <= m_cmd_d;
            m_valid_q  <= m_valid_d;
            m_wdata_q  <= m_wdata_d;
            creg_q     <= creg_d;
            cval_q     <= cval_d;
            rreg_q     <= rreg_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Command and write byte implied by the current sequencer step
    always_comb begin
        w_last  = (LEN_W'(byte_cnt_q) == len_q - LEN_W'(1));
        w_cmd   = c_cmd_write;
        w_wdata = 8'h00;
        case (state_q)
            ST_C_START, ST_R_START, ST_R_RSTART: w_cmd = c_cmd_start;
            ST_C_STOP, ST_STOP:                  w_cmd = c_cmd_stop;
            ST_R_READ:  w_cmd = w_last ? c_cmd_rnack : c_cmd_rack;
            ST_C_ADDR, ST_R_ADDRW: w_wdata = {DEV_ADDR, 1'b0};
            ST_C_REG:   w_wdata = creg_q;
            ST_C_VAL:   w_wdata = cval_q;
            ST_R_REG:   w_wdata = rreg_q;
            ST_R_ADDRR: w_wdata = {DEV_ADDR, 1'b1};
            default:    w_wdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_d     = nack_q;
        tmo_d      = tmo_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_idx_d   = rd_idx_q;
        m_cmd_d    = m_cmd_q;
        m_valid_d  = m_valid_q;
        m_wdata_d  = m_wdata_q;
        creg_d     = creg_q;
        cval_d     = cval_q;
        rreg_d     = rreg_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = poll_en ? cnt_q + CNT_W'(1) : '0;
                if (trig || (poll_en && cnt_q == c_poll_last)) begin
                    creg_d     = conv_reg;
                    cval_d     = conv_val;
                    rreg_d     = rd_reg;
                    if (rd_len == '0)
                        len_d = LEN_W'(1);
                    else if (rd_len > LEN_W'(MAX_BYTES))
                        len_d = LEN_W'(MAX_BYTES);
                    else
                        len_d = rd_len;
                    nack_d     = 1'b0;
                    tmo_d      = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    byte_cnt_d = '0;
                    state_d    = conv_en ? ST_C_START : ST_R_START;
                end
            end
            ST_WAIT: begin
                if (cnt_q == c_conv_last) begin
                    cnt_d   = '0;
                    state_d = ST_R_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (!m_valid_q) begin
                    m_valid_d = 1'b1;
                    m_cmd_d   = w_cmd;
                    m_wdata_d = w_wdata;
                    cnt_d     = '0;
                end else if (m_done) begin
                    m_valid_d = 1'b0;
                    cnt_d     = '0;
                    if (m_cmd_q == c_cmd_write && !m_ack) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        case (state_q)
                            ST_C_START:  state_d = ST_C_ADDR;
                            ST_C_ADDR:   state_d = ST_C_REG;
                            ST_C_REG:    state_d = ST_C_VAL;
                            ST_C_VAL:    state_d = ST_C_STOP;
                            ST_C_STOP:   state_d = ST_WAIT;
                            ST_R_START:  state_d = ST_R_ADDRW;
                            ST_R_ADDRW:  state_d = ST_R_REG;
                            ST_R_REG:    state_d = ST_R_RSTART;
                            ST_R_RSTART: state_d = ST_R_ADDRR;
                            ST_R_ADDRR:  state_d = ST_R_READ;
                            ST_R_READ: begin
                                rd_valid_d = 1'b1;
                                rd_data_d  = m_rdata;
                                rd_idx_d   = byte_cnt_q;
                                if (w_last)
                                    state_d = ST_STOP;
                                else
                                    byte_cnt_d = byte_cnt_q + IDX_W'(1);
                            end
                            default: begin
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                end else if (cnt_q == c_tmo_last) begin
                    // Abandon the bus without a STOP: the master is presumed stuck
                    tmo_d     = 1'b1;
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_q;
    assign tmo_err  = tmo_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_idx   = rd_idx_q;
    assign m_cmd    = m_cmd_q;
    assign m_valid  = m_valid_q;
    assign m_wdata  = m_wdata_q;

endmodule
`default_nettype wire
